// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access-size
// byte enables and the alignment legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RSP  = 2'd3
    } t_lsu_state;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // An access is legal only for a known size that is naturally aligned.
    function automatic logic lsu_access_legal(input logic [3:0] byt_en, input logic [1:0] off);
        case (byt_en)
            BE_BYTE: return 1'b1;
            BE_HALF: return ~off[0];
            BE_WORD: return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response interface and req/gnt/rvalid data-memory bus
// interface of the load/store unit.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byt_en;
    logic        req_wr_en;
    logic        req_sign_ext;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;

    modport master (
        output req_valid, req_addr, req_wdata, req_byt_en, req_wr_en, req_sign_ext,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_byt_en, req_wr_en, req_sign_ext,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Moves the addressed bytes of a raw read word down to bit 0 and applies
// the size mask with optional sign extension.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [3:0]  byt_en_i,
    input  logic        sign_ext_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (byt_en_i)
            BE_BYTE: data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            BE_HALF: data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one core access at a time on a req/gnt/rvalid bus.
// Define LSU_TIMEOUT_EN to add a bus-wait watchdog of TIMEOUT_CYCLES cycles.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  core_if,
    lsu_mem_if.master mem_if
);

    t_lsu_state  state_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic        sext_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic [1:0]  req_off;
    logic [3:0]  mem_be_d;
    logic [31:0] mem_wdata_d;
    logic [31:0] load_data;
    logic        timeout_hit;

    assign req_off     = core_if.req_addr[1:0];
    assign mem_be_d    = core_if.req_byt_en << req_off;
    assign mem_wdata_d = core_if.req_wdata << {req_off, 3'b000};

    lsu_load_align u_load_align (
        .rdata_i   (mem_if.mem_rdata),
        .offset_i  (off_q),
        .byt_en_i  (be_q),
        .sign_ext_i(sext_q),
        .data_o    (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt_q;

    // Zero outside the bus phases, so each access starts REQ from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == LSU_REQ || state_q == LSU_WAIT) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign timeout_hit = (to_cnt_q >= TO_LAST);
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            off_q       <= '0;
            be_q        <= '0;
            sext_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (core_if.req_valid) begin
                        off_q  <= req_off;
                        be_q   <= core_if.req_byt_en;
                        sext_q <= core_if.req_sign_ext;
                        if (lsu_access_legal(core_if.req_byt_en, req_off)) begin
                            state_q     <= LSU_REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= core_if.req_wr_en;
                            mem_addr_q  <= {core_if.req_addr[31:2], 2'b00};
                            mem_be_q    <= mem_be_d;
                            mem_wdata_q <= mem_wdata_d;
                        end else begin
                            state_q     <= LSU_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    // A grant wins over a coinciding timeout: the bus owns the access.
                    if (mem_if.mem_gnt) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        if (mem_we_q) begin
                            state_q     <= LSU_RSP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= LSU_WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        state_q     <= LSU_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                LSU_WAIT: begin
                    if (mem_if.mem_rvalid) begin
                        state_q     <= LSU_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_data;
                    end else if (timeout_hit) begin
                        state_q     <= LSU_RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                    end
                end
                LSU_RSP: begin
                    state_q     <= LSU_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign core_if.req_ready = (state_q == LSU_IDLE);
    assign core_if.rsp_valid = rsp_valid_q;
    assign core_if.rsp_rdata = rsp_rdata_q;
    assign core_if.rsp_err   = rsp_err_q;
    assign core_if.stall     = core_if.req_valid & ~rsp_valid_q;

    assign mem_if.mem_req   = mem_req_q;
    assign mem_if.mem_we    = mem_we_q;
    assign mem_if.mem_addr  = mem_addr_q;
    assign mem_if.mem_be    = mem_be_q;
    assign mem_if.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: loads, stores, lane alignment, illegal accesses,
// reset mid-access and (with LSU_TIMEOUT_EN) the bus watchdog.
module tb_lsu;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    lsu_req_if core_if ();
    lsu_mem_if mem_if ();

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .core_if(core_if),
        .mem_if (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "tb_lsu stopped by watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_if.req_valid    = 1'b0;
        core_if.req_addr     = '0;
        core_if.req_wdata    = '0;
        core_if.req_byt_en   = '0;
        core_if.req_wr_en    = 1'b0;
        core_if.req_sign_ext = 1'b0;
        mem_if.mem_gnt       = 1'b0;
        mem_if.mem_rvalid    = 1'b0;
        mem_if.mem_rdata     = '0;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, input logic we, input logic sext);
        core_if.req_valid    = 1'b1;
        core_if.req_addr     = addr;
        core_if.req_wdata    = wdata;
        core_if.req_byt_en   = be;
        core_if.req_wr_en    = we;
        core_if.req_sign_ext = sext;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #12;
        checks++; if (mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b want=0", mem_if.mem_req); end
        checks++; if (mem_if.mem_be !== 4'h0 || mem_if.mem_addr !== 32'h0 || mem_if.mem_wdata !== 32'h0 || mem_if.mem_we !== 1'b0) begin
            failures++; $display("FAIL rst_mem_fields got be=%h addr=%h wdata=%h we=%b want all 0", mem_if.mem_be, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_we); end
        checks++; if (core_if.rsp_valid !== 1'b0 || core_if.rsp_err !== 1'b0 || core_if.rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_rsp got valid=%b err=%b rdata=%h want 0 0 0", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (core_if.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", core_if.req_ready); end
        checks++; if (core_if.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b want=0", core_if.stall); end
    endtask

    task automatic test_lw();
        step(); drive_req(32'h100, 32'h0, 4'b1111, 1'b0, 1'b0); mem_if.mem_gnt = 1'b1;
        @(negedge clk);
        checks++; if (core_if.stall !== 1'b1 || mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL lw_c0 got stall=%b req=%b want 1 0", core_if.stall, mem_if.mem_req); end
        step(); @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0) begin failures++; $display("FAIL lw_c1_req got req=%b we=%b want 1 0", mem_if.mem_req, mem_if.mem_we); end
        checks++; if (mem_if.mem_be !== 4'b1111 || mem_if.mem_addr !== 32'h100) begin failures++; $display("FAIL lw_c1_bus got be=%b addr=%h want 1111 00000100", mem_if.mem_be, mem_if.mem_addr); end
        checks++; if (core_if.stall !== 1'b1) begin failures++; $display("FAIL lw_c1_stall got=%b want=1", core_if.stall); end
        step(); mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b0 || core_if.rsp_valid !== 1'b0 || core_if.stall !== 1'b1) begin
            failures++; $display("FAIL lw_c2 got req=%b rsp=%b stall=%b want 0 0 1", mem_if.mem_req, core_if.rsp_valid, core_if.stall); end
        step(); mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
        @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_err !== 1'b0) begin failures++; $display("FAIL lw_c3_rsp got valid=%b err=%b want 1 0", core_if.rsp_valid, core_if.rsp_err); end
        checks++; if (core_if.rsp_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_c3_rdata got=%h want=deadbeef", core_if.rsp_rdata); end
        checks++; if (core_if.stall !== 1'b0) begin failures++; $display("FAIL lw_c3_stall got=%b want=0", core_if.stall); end
        step(); idle_inputs();
        @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b0 || core_if.rsp_rdata !== 32'h0 || core_if.req_ready !== 1'b1) begin
            failures++; $display("FAIL lw_c4 got valid=%b rdata=%h ready=%b want 0 0 1", core_if.rsp_valid, core_if.rsp_rdata, core_if.req_ready); end
    endtask

    task automatic test_load_ext();
        logic [31:0] a_t [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h105, 32'h000};
        logic [3:0]  b_t [6] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0001, 4'b1111};
        logic        s_t [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] r_t [6] = '{32'h80000000, 32'h80000000, 32'h92345678, 32'h92345678, 32'h11227F44, 32'h80000001};
        logic [3:0]  eb_t[6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010, 4'b1111};
        logic [31:0] ea_t[6] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h104, 32'h000};
        logic [31:0] ed_t[6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9234, 32'h00009234, 32'h0000007F, 32'h80000001};
        for (int i = 0; i < 6; i++) begin
            step(); drive_req(a_t[i], 32'h0, b_t[i], 1'b0, s_t[i]); mem_if.mem_gnt = 1'b1;
            step(); @(negedge clk);
            checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_be !== eb_t[i] || mem_if.mem_addr !== ea_t[i]) begin
                failures++; $display("FAIL ext%0d_bus got req=%b be=%b addr=%h want 1 %b %h", i, mem_if.mem_req, mem_if.mem_be, mem_if.mem_addr, eb_t[i], ea_t[i]); end
            step(); mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = r_t[i];
            step(); mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
            @(negedge clk);
            checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_rdata !== ed_t[i] || core_if.rsp_err !== 1'b0) begin
                failures++; $display("FAIL ext%0d_rsp got valid=%b rdata=%h err=%b want 1 %h 0", i, core_if.rsp_valid, core_if.rsp_rdata, core_if.rsp_err, ed_t[i]); end
            step(); idle_inputs();
        end
    endtask

    task automatic test_store_delayed_gnt();
        int pulses = 0;
        step(); drive_req(32'h202, 32'h0000ABCD, 4'b0011, 1'b1, 1'b0); mem_if.mem_gnt = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step(); if (c == 4) mem_if.mem_gnt = 1'b1;
            @(negedge clk);
            if (core_if.rsp_valid === 1'b1) pulses++;
            checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b1 || mem_if.mem_be !== 4'b1100 || mem_if.mem_wdata !== 32'hABCD0000 || mem_if.mem_addr !== 32'h200) begin
                failures++; $display("FAIL sh_hold_c%0d got req=%b we=%b be=%b wdata=%h addr=%h want 1 1 1100 abcd0000 00000200",
                                     c, mem_if.mem_req, mem_if.mem_we, mem_if.mem_be, mem_if.mem_wdata, mem_if.mem_addr); end
        end
        step(); mem_if.mem_gnt = 1'b0;
        @(negedge clk);
        if (core_if.rsp_valid === 1'b1) pulses++;
        checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_rdata !== 32'h0 || core_if.rsp_err !== 1'b0 || mem_if.mem_req !== 1'b0) begin
            failures++; $display("FAIL sh_rsp got valid=%b rdata=%h err=%b req=%b want 1 0 0 0", core_if.rsp_valid, core_if.rsp_rdata, core_if.rsp_err, mem_if.mem_req); end
        for (int c = 6; c <= 7; c++) begin
            step(); idle_inputs();
            @(negedge clk);
            if (core_if.rsp_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL sh_pulses got=%0d want=1", pulses); end
    endtask

    task automatic test_store_fast();
        step(); drive_req(32'h301, 32'h0000005A, 4'b0001, 1'b1, 1'b0);
        mem_if.mem_gnt = 1'b1; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hFFFFFFFF;
        step(); @(negedge clk);
        checks++; if (mem_if.mem_be !== 4'b0010 || mem_if.mem_wdata !== 32'h00005A00 || mem_if.mem_addr !== 32'h300 || mem_if.mem_we !== 1'b1) begin
            failures++; $display("FAIL sb_bus got be=%b wdata=%h addr=%h we=%b want 0010 00005a00 00000300 1", mem_if.mem_be, mem_if.mem_wdata, mem_if.mem_addr, mem_if.mem_we); end
        step(); @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_rdata !== 32'h0 || core_if.rsp_err !== 1'b0) begin
            failures++; $display("FAIL sb_rsp got valid=%b rdata=%h err=%b want 1 0 0", core_if.rsp_valid, core_if.rsp_rdata, core_if.rsp_err); end
        step(); idle_inputs();
        @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b0 || core_if.req_ready !== 1'b1) begin
            failures++; $display("FAIL sb_after got valid=%b ready=%b want 0 1", core_if.rsp_valid, core_if.req_ready); end
    endtask

    task automatic test_illegal();
        logic [31:0] a_t [5] = '{32'h101, 32'h100, 32'h201, 32'h100, 32'h102};
        logic [3:0]  b_t [5] = '{4'b1111, 4'b0000, 4'b0011, 4'b0111, 4'b1111};
        for (int i = 0; i < 5; i++) begin
            step(); drive_req(a_t[i], 32'h12345678, b_t[i], 1'b0, 1'b1); mem_if.mem_gnt = 1'b1;
            @(negedge clk);
            checks++; if (mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL ill%0d_c0_req got=%b want=0", i, mem_if.mem_req); end
            step(); @(negedge clk);
            checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_err !== 1'b1 || core_if.rsp_rdata !== 32'h0 || mem_if.mem_req !== 1'b0) begin
                failures++; $display("FAIL ill%0d_rsp got valid=%b err=%b rdata=%h req=%b want 1 1 0 0", i, core_if.rsp_valid, core_if.rsp_err, core_if.rsp_rdata, mem_if.mem_req); end
            step(); idle_inputs();
            @(negedge clk);
            checks++; if (core_if.rsp_valid !== 1'b0 || core_if.rsp_err !== 1'b0 || mem_if.mem_req !== 1'b0 || core_if.req_ready !== 1'b1) begin
                failures++; $display("FAIL ill%0d_after got valid=%b err=%b req=%b ready=%b want 0 0 0 1", i, core_if.rsp_valid, core_if.rsp_err, mem_if.mem_req, core_if.req_ready); end
        end
    endtask

    task automatic test_back_to_back();
        step(); drive_req(32'h500, 32'h12345678, 4'b1111, 1'b1, 1'b0); mem_if.mem_gnt = 1'b1;
        step(); @(negedge clk);
        checks++; if (mem_if.mem_wdata !== 32'h12345678 || mem_if.mem_be !== 4'b1111 || mem_if.mem_addr !== 32'h500) begin
            failures++; $display("FAIL b2b_sw_bus got wdata=%h be=%b addr=%h want 12345678 1111 00000500", mem_if.mem_wdata, mem_if.mem_be, mem_if.mem_addr); end
        step(); @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_sw_rsp got=%b want=1", core_if.rsp_valid); end
        step(); drive_req(32'h506, 32'h0, 4'b0011, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (core_if.req_ready !== 1'b1 || core_if.stall !== 1'b1) begin
            failures++; $display("FAIL b2b_lh_accept got ready=%b stall=%b want 1 1", core_if.req_ready, core_if.stall); end
        step(); @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_be !== 4'b1100 || mem_if.mem_addr !== 32'h504 || mem_if.mem_we !== 1'b0) begin
            failures++; $display("FAIL b2b_lh_bus got req=%b be=%b addr=%h we=%b want 1 1100 00000504 0", mem_if.mem_req, mem_if.mem_be, mem_if.mem_addr, mem_if.mem_we); end
        step(); mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h87651234;
        step(); mem_if.mem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_rdata !== 32'hFFFF8765) begin
            failures++; $display("FAIL b2b_lh_rsp got valid=%b rdata=%h want 1 ffff8765", core_if.rsp_valid, core_if.rsp_rdata); end
        step(); idle_inputs();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        step(); drive_req(32'h300, 32'h0, 4'b1111, 1'b0, 1'b0); mem_if.mem_gnt = 1'b1;
        step(); step(); mem_if.mem_gnt = 1'b0;
        @(negedge clk);
        checks++; if (core_if.req_ready !== 1'b0) begin failures++; $display("FAIL rstw_busy got ready=%b want=0", core_if.req_ready); end
        #1; rst_n = 1'b0; core_if.req_valid = 1'b0;
        #1;
        checks++; if (mem_if.mem_req !== 1'b0 || core_if.req_ready !== 1'b1) begin
            failures++; $display("FAIL rstw_now got req=%b ready=%b want 0 1", mem_if.mem_req, core_if.req_ready); end
        #1; rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(); mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h00001234;
            @(negedge clk);
            if (core_if.rsp_valid !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL rstw_late_rvalid got rsp cycles=%0d want=0", pulses); end
        step(); idle_inputs();
        step(); drive_req(32'h310, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0);
        step(); @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b1) begin failures++; $display("FAIL rstr_req got=%b want=1", mem_if.mem_req); end
        #1; rst_n = 1'b0; core_if.req_valid = 1'b0;
        #1;
        checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_wdata !== 32'h0 || core_if.req_ready !== 1'b1) begin
            failures++; $display("FAIL rstr_now got req=%b wdata=%h ready=%b want 0 0 1", mem_if.mem_req, mem_if.mem_wdata, core_if.req_ready); end
        #1; rst_n = 1'b1;
        step(); @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b0 || core_if.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rstr_after got req=%b rsp=%b want 0 0", mem_if.mem_req, core_if.rsp_valid); end
        idle_inputs();
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        step(); drive_req(32'h400, 32'h11111111, 4'b1111, 1'b1, 1'b0); mem_if.mem_gnt = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step(); @(negedge clk);
            checks++; if (mem_if.mem_req !== 1'b1) begin failures++; $display("FAIL to_st_req_c%0d got=%b want=1", c, mem_if.mem_req); end
        end
        step(); @(negedge clk);
        checks++; if (mem_if.mem_req !== 1'b0 || core_if.rsp_valid !== 1'b1 || core_if.rsp_err !== 1'b1 || core_if.rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL to_st_rsp got req=%b valid=%b err=%b rdata=%h want 0 1 1 0", mem_if.mem_req, core_if.rsp_valid, core_if.rsp_err, core_if.rsp_rdata); end
        step(); idle_inputs();
        step(); drive_req(32'h404, 32'h0, 4'b1111, 1'b0, 1'b0); mem_if.mem_gnt = 1'b1;
        step(); step(); mem_if.mem_gnt = 1'b0;
        step(); step();
        @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b0) begin failures++; $display("FAIL to_ld_early got=%b want=0", core_if.rsp_valid); end
        step(); @(negedge clk);
        checks++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_err !== 1'b1 || core_if.rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL to_ld_rsp got valid=%b err=%b rdata=%h want 1 1 0", core_if.rsp_valid, core_if.rsp_err, core_if.rsp_rdata); end
        step(); core_if.req_valid = 1'b0; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hABCDEF01;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (core_if.rsp_valid !== 1'b0) pulses++;
            step();
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL to_late_rvalid got rsp cycles=%0d want=0", pulses); end
        idle_inputs();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store_delayed_gnt();
        test_store_fast();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
